// File: rtl/rv32v_hazard_unit.sv
// Stall/flush controller for the RV32V vector pipeline, with CSR-write flush and front-end drain sequencing.
// Optional statistics counters are enabled with `define RV32V_HAZARD_STATS_EN.
module rv32v_hazard_unit #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        busy_f1,
  input  logic        busy_f2,
  input  logic        busy_dec,
  input  logic        busy_ex,
  input  logic        busy_mem,
  input  logic        csr_update,
  output logic        stall_f1,
  output logic        stall_f2,
  output logic        stall_dec,
  output logic        stall_ex,
  output logic        stall_mem,
  output logic        flush_f1,
  output logic        flush_f2,
  output logic        flush_dec,
  output logic        flush_ex,
  output logic        flush_mem
`ifdef RV32V_HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] csr_flushes
`endif
);

  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic          csr_flush_s;
  logic          chain_f1_s, chain_f2_s, chain_dec_s, chain_ex_s, chain_mem_s;

  // A CSR flush fires once the memory stage can actually commit the write.
  always_comb begin
    csr_flush_s = 1'b0;
    if (RST) begin
      csr_flush_s = 1'b0;
    end else if (((state_r == IDLE) || (state_r == DRAIN)) && csr_update && !busy_mem) begin
      csr_flush_s = 1'b1;
    end else if ((state_r == PEND) && !busy_mem) begin
      csr_flush_s = 1'b1;
    end else begin
      csr_flush_s = 1'b0;
    end
  end

  // Back-propagating stall chain; fetch1 is held while draining.
  always_comb begin
    chain_mem_s = busy_mem;
    chain_ex_s  = busy_ex  | chain_mem_s;
    chain_dec_s = busy_dec | chain_ex_s;
    chain_f2_s  = busy_f2  | chain_dec_s;
    chain_f1_s  = busy_f1  | chain_f2_s | (state_r == DRAIN);
  end

  // Output selection: reset silences everything, a CSR flush overrides any busy.
  always_comb begin
    {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} = 5'b00000;
    {flush_f1, flush_f2, flush_dec, flush_ex, flush_mem} = 5'b00000;
    if (RST) begin
      {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} = 5'b00000;
      {flush_f1, flush_f2, flush_dec, flush_ex, flush_mem} = 5'b00000;
    end else if (csr_flush_s) begin
      {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} = 5'b00000;
      {flush_f1, flush_f2, flush_dec, flush_ex, flush_mem} = 5'b11111;
    end else begin
      {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} =
        {chain_f1_s, chain_f2_s, chain_dec_s, chain_ex_s, chain_mem_s};
      flush_f1  = 1'b0;
      flush_f2  = chain_f1_s  & ~chain_f2_s;
      flush_dec = chain_f2_s  & ~chain_dec_s;
      flush_ex  = chain_dec_s & ~chain_ex_s;
      flush_mem = chain_ex_s  & ~chain_mem_s;
    end
  end

  // Flush/drain sequencer state and drain counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else if (csr_flush_s) begin
      if (DRAIN_CYCLES == 0) begin
        state_r <= IDLE;
        cnt_r   <= {CW{1'b0}};
      end else begin
        state_r <= DRAIN;
        cnt_r   <= CW'(DRAIN_CYCLES);
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (csr_update) begin
            state_r <= PEND;
          end else begin
            state_r <= IDLE;
          end
          cnt_r <= {CW{1'b0}};
        end
        PEND: begin
          state_r <= PEND;
          cnt_r   <= {CW{1'b0}};
        end
        DRAIN: begin
          if (csr_update) begin
            state_r <= PEND;
            cnt_r   <= {CW{1'b0}};
          end else if (cnt_r == CW'(1'b1)) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
          end else begin
            state_r <= DRAIN;
            cnt_r   <= cnt_r - CW'(1'b1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

`ifdef RV32V_HAZARD_STATS_EN
  // Free-running, silently wrapping performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= 32'd0;
      csr_flushes  <= 16'd0;
    end else begin
      if (stall_f1) begin
        stall_cycles <= stall_cycles + 32'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (csr_flush_s) begin
        csr_flushes <= csr_flushes + 16'd1;
      end else begin
        csr_flushes <= csr_flushes;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv32v_hazard_unit.sv
// Scoreboard bench for rv32v_hazard_unit (DRAIN_CYCLES=2): directed vectors with hand-computed outputs.
module tb_rv32v_hazard_unit;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic busy_f1 = 1'b0, busy_f2 = 1'b0, busy_dec = 1'b0, busy_ex = 1'b0, busy_mem = 1'b0;
  logic csr_update = 1'b0;
  logic stall_f1, stall_f2, stall_dec, stall_ex, stall_mem;
  logic flush_f1, flush_f2, flush_dec, flush_ex, flush_mem;
`ifdef RV32V_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] csr_flushes;
`endif

  rv32v_hazard_unit #(.DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST),
    .busy_f1(busy_f1), .busy_f2(busy_f2), .busy_dec(busy_dec), .busy_ex(busy_ex), .busy_mem(busy_mem),
    .csr_update(csr_update),
    .stall_f1(stall_f1), .stall_f2(stall_f2), .stall_dec(stall_dec), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_f1(flush_f1), .flush_f2(flush_f2), .flush_dec(flush_dec), .flush_ex(flush_ex), .flush_mem(flush_mem)
`ifdef RV32V_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .csr_flushes(csr_flushes)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] exp;
    logic       rst;
    string      tag;
  } item_t;

  item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Drive one cycle of stimulus and queue its expected {stall f1..mem, flush f1..mem}.
  task automatic step(input logic r, input logic [4:0] b, input logic c,
                      input logic [4:0] es, input logic [4:0] ef, input string tag);
    item_t it;
    @(posedge CLK);
    #1;
    RST = r;
    {busy_f1, busy_f2, busy_dec, busy_ex, busy_mem} = b;
    csr_update = c;
    it.exp = {es, ef};
    it.rst = r;
    it.tag = tag;
    sb_q.push_back(it);
  endtask

  // Monitor: outputs are combinational, so compare every cycle mid-period.
  initial begin
    item_t it;
    logic [9:0] act;
    int mf = 0;
    int ms = 0;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        act = {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem,
               flush_f1, flush_f2, flush_dec, flush_ex, flush_mem};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got stall=%b flush=%b, expected stall=%b flush=%b",
                   it.tag, act[9:5], act[4:0], it.exp[9:5], it.exp[4:0]);
        end
`ifdef RV32V_HAZARD_STATS_EN
        checks++;
        if (csr_flushes !== 16'(mf)) begin
          errors++;
          $display("FAIL %s csr_flushes: got %0d expected %0d", it.tag, csr_flushes, mf);
        end
        checks++;
        if (stall_cycles !== 32'(ms)) begin
          errors++;
          $display("FAIL %s stall_cycles: got %0d expected %0d", it.tag, stall_cycles, ms);
        end
        if (it.rst) begin
          mf = 0;
          ms = 0;
        end else begin
          if (it.exp[4:0] == 5'b11111) mf++;
          if (it.exp[9]) ms++;
        end
`endif
      end
    end
  end

  initial begin
    // busy = {f1,f2,dec,ex,mem}; expected stall and flush in the same order.
    step(1'b1, 5'b00000, 1'b0, 5'b00000, 5'b00000, "reset_quiet");
    step(1'b1, 5'b11111, 1'b1, 5'b00000, 5'b00000, "reset_busy");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "idle0");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "idle1");
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'b00010, 1'b0, 5'b11110, 5'b00001, "busy_ex");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "after_busy_ex");
    step(1'b0, 5'b01000, 1'b0, 5'b11000, 5'b00100, "busy_f2");
    step(1'b0, 5'b00001, 1'b0, 5'b11111, 5'b00000, "busy_mem");
    step(1'b0, 5'b00100, 1'b0, 5'b11100, 5'b00010, "busy_dec");
    step(1'b0, 5'b10000, 1'b0, 5'b10000, 5'b01000, "busy_f1");
    step(1'b0, 5'b01001, 1'b0, 5'b11111, 5'b00000, "busy_f2_mem");
    // Immediate CSR flush, overriding busy_dec/busy_ex, then 2-cycle drain.
    step(1'b0, 5'b00110, 1'b1, 5'b00000, 5'b11111, "csr_flush_wins");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "drain1");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "drain2");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "post_drain_idle");
    // Deferred flush: memory busy, csr_update drops while pending.
    step(1'b0, 5'b00001, 1'b1, 5'b11111, 5'b00000, "pend_enter");
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'b00001, 1'b0, 5'b11111, 5'b00000, "pend_hold");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b11111, "pend_flush");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "pend_drain1");
    step(1'b0, 5'b00100, 1'b0, 5'b11100, 5'b00010, "pend_drain2_busy_dec");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "pend_idle");
    // Second CSR write in the first drain cycle restarts the flush and drain.
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 5'b11111, "restart_first");
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 5'b11111, "restart_second");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "restart_drain1");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "restart_drain2");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "restart_idle");
    // CSR write during drain while memory is busy goes to PEND.
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 5'b11111, "drain_pend_flush");
    step(1'b0, 5'b00001, 1'b1, 5'b11111, 5'b00000, "drain_to_pend");
    step(1'b0, 5'b00001, 1'b0, 5'b11111, 5'b00000, "drain_pend_hold");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b11111, "drain_pend_fire");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "drain_pend_d1");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "drain_pend_d2");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "drain_pend_idle");
    // Reset taken in PEND discards the pending flush.
    step(1'b0, 5'b00001, 1'b1, 5'b11111, 5'b00000, "rst_pend_enter");
    step(1'b1, 5'b00000, 1'b0, 5'b00000, 5'b00000, "rst_in_pend");
    step(1'b1, 5'b00001, 1'b0, 5'b00000, 5'b00000, "rst_in_pend_busy");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "rst_pend_release");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "rst_pend_idle");
    // Reset taken mid-drain cancels the drain.
    step(1'b0, 5'b00000, 1'b1, 5'b00000, 5'b11111, "rst_drain_flush");
    step(1'b0, 5'b00000, 1'b0, 5'b10000, 5'b01000, "rst_drain_d1");
    step(1'b1, 5'b00000, 1'b0, 5'b00000, 5'b00000, "rst_in_drain");
    step(1'b0, 5'b00000, 1'b0, 5'b00000, 5'b00000, "rst_drain_release");
    step(1'b0, 5'b00010, 1'b0, 5'b11110, 5'b00001, "rst_drain_busy_ex");

    @(posedge CLK);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
